// File: rtl/apu_power_seq.sv
// rtl/apu_power_seq.sv - APU master power sequencer and per-channel lifecycle/status tracking
// Master FSM OFF -> RSEQ -> ON issues timed reset pulses; channels track active status in ON.
module apu_power_seq #(
  parameter int NUM_CH       = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              master_en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] pause,
  output logic [NUM_CH-1:0] ch_reset,
  output logic [NUM_CH-1:0] status,
  output logic              master_on
);

  localparam int              CW     = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(RESET_CYCLES);
  localparam logic [CW-1:0]   ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RSEQ = 2'd1,
    S_ON   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     rseq_cnt_q, rseq_cnt_d;
  logic [CW-1:0]     ch_cnt_q [NUM_CH];
  logic [CW-1:0]     ch_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] prev_en_q;
  logic [NUM_CH-1:0] en_rise;

  // prev_en_q holds the RSEQ-time sample on the first ON cycle, so enables
  // already high at power-on do not look like a rising edge.
  assign en_rise = ch_en & ~prev_en_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_OFF;
      rseq_cnt_q <= '0;
      active_q   <= '0;
      prev_en_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rseq_cnt_q <= rseq_cnt_d;
      active_q   <= active_d;
      prev_en_q  <= ch_en;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_q[i] <= ch_cnt_d[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rseq_cnt_d = rseq_cnt_q;
    active_d   = active_q;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_cnt_d[i] = ch_cnt_q[i];
    end

    if (!master_en) begin
      state_d    = S_OFF;
      rseq_cnt_d = '0;
      active_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_OFF: begin
          state_d    = S_RSEQ;
          rseq_cnt_d = RELOAD;
        end
        S_RSEQ: begin
          if (rseq_cnt_q <= ONE) begin
            state_d    = S_ON;
            rseq_cnt_d = '0;
            active_d   = ch_en;
            for (int i = 0; i < NUM_CH; i++) begin
              ch_cnt_d[i] = '0;
            end
          end else begin
            rseq_cnt_d = rseq_cnt_q - ONE;
          end
        end
        S_ON: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_cnt_q[i] != '0) begin
              ch_cnt_d[i] = ch_cnt_q[i] - ONE;
            end
            if (!ch_en[i]) begin
              active_d[i] = 1'b0;
            end else if (trigger[i] || en_rise[i]) begin
              active_d[i] = 1'b1;
              ch_cnt_d[i] = RELOAD;
            end else if (ch_done[i]) begin
              active_d[i] = 1'b0;
            end
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  // ch_en enters pause through its registered copy to keep outputs register-decoded.
  always_comb begin
    master_on = (state_q == S_ON);
    ch_reset  = '0;
    pause     = '1;
    status    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_reset[i] = (state_q == S_RSEQ) || ((state_q == S_ON) && (ch_cnt_q[i] != '0));
      pause[i]    = ~((state_q == S_ON) && prev_en_q[i] && active_q[i]) | ch_reset[i];
      status[i]   = (state_q == S_ON) && active_q[i];
    end
  end

endmodule

// File: tb/tb_apu_power_seq.sv
// tb/tb_apu_power_seq.sv - directed self-checking bench for apu_power_seq
// Observed vectors are {pause, ch_reset, status, master_on}.
module tb_apu_power_seq;

  logic       clock;
  logic       reset_a, master_en_a;
  logic [3:0] ch_en_a, trigger_a, ch_done_a, pause_a, ch_reset_a, status_a;
  logic       master_on_a;
  logic       reset_b, master_en_b;
  logic [5:0] ch_en_b, trigger_b, ch_done_b, pause_b, ch_reset_b, status_b;
  logic       master_on_b;

  logic [12:0] obs_a;
  logic [18:0] obs_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign obs_a = {pause_a, ch_reset_a, status_a, master_on_a};
  assign obs_b = {pause_b, ch_reset_b, status_b, master_on_b};

  apu_power_seq #(.NUM_CH(4), .RESET_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset_a), .master_en(master_en_a),
    .ch_en(ch_en_a), .trigger(trigger_a), .ch_done(ch_done_a),
    .pause(pause_a), .ch_reset(ch_reset_a), .status(status_a), .master_on(master_on_a)
  );

  apu_power_seq #(.NUM_CH(6), .RESET_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset_b), .master_en(master_en_b),
    .ch_en(ch_en_b), .trigger(trigger_b), .ch_done(ch_done_b),
    .pause(pause_b), .ch_reset(ch_reset_b), .status(status_b), .master_on(master_on_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] exp_a;
    logic [18:0] exp_b;
    #1;
    exp_a = {4'hF, 4'h0, 4'h0, 1'b0};
    exp_b = {6'h3F, 6'h0, 6'h0, 1'b0};
    n_tests++; if (obs_a !== exp_a) begin $display("FAIL reset_a got %b want %b", obs_a, exp_a); n_fail++; end
    n_tests++; if (obs_b !== exp_b) begin $display("FAIL reset_b got %b want %b", obs_b, exp_b); n_fail++; end
    tick;
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick;
    n_tests++; if (obs_a !== exp_a) begin $display("FAIL off_idle got %b want %b", obs_a, exp_a); n_fail++; end
  endtask

  task automatic test_power_up;
    logic [12:0] exp;
    ch_en_a = 4'b0101;
    master_en_a = 1'b1;
    tick;
    exp = {4'hF, 4'hF, 4'h0, 1'b0};
    n_tests++; if (obs_a !== exp) begin $display("FAIL pwr_rseq1 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    n_tests++; if (obs_a !== exp) begin $display("FAIL pwr_rseq2 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    exp = {4'b1010, 4'b0000, 4'b0101, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL pwr_on got %b want %b", obs_a, exp); n_fail++; end
    tick;
    n_tests++; if (obs_a !== exp) begin $display("FAIL pwr_no_extra got %b want %b", obs_a, exp); n_fail++; end
  endtask

  task automatic test_trigger;
    logic [12:0] exp;
    int          hi;
    ch_en_a = 4'b0111;
    tick;
    exp = {4'b1010, 4'b0010, 4'b0111, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL rise_pulse got %b want %b", obs_a, exp); n_fail++; end
    tick;
    tick;
    exp = {4'b1000, 4'b0000, 4'b0111, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL rise_done got %b want %b", obs_a, exp); n_fail++; end
    trigger_a = 4'b0010;
    tick;
    trigger_a = 4'b0000;
    exp = {4'b1010, 4'b0010, 4'b0111, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL trig_c1 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    n_tests++; if (obs_a !== exp) begin $display("FAIL trig_c2 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    exp = {4'b1000, 4'b0000, 4'b0111, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL trig_release got %b want %b", obs_a, exp); n_fail++; end
    hi = 0;
    trigger_a = 4'b0010;
    tick;
    hi += int'(ch_reset_a[1]);
    tick;
    hi += int'(ch_reset_a[1]);
    trigger_a = 4'b0000;
    repeat (5) begin
      tick;
      hi += int'(ch_reset_a[1]);
    end
    n_tests++; if (hi !== 3) begin $display("FAIL retrig_len got %0d want 3", hi); n_fail++; end
  endtask

  task automatic test_length;
    logic [12:0] exp;
    ch_done_a = 4'b0100;
    tick;
    ch_done_a = 4'b0000;
    exp = {4'b1100, 4'b0000, 4'b0011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL done_c2 got %b want %b", obs_a, exp); n_fail++; end
    ch_en_a = 4'b1111;
    tick;
    tick;
    tick;
    exp = {4'b0100, 4'b0000, 4'b1011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL en3_up got %b want %b", obs_a, exp); n_fail++; end
    ch_done_a = 4'b1000;
    tick;
    ch_done_a = 4'b0000;
    exp = {4'b1100, 4'b0000, 4'b0011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL done_c3 got %b want %b", obs_a, exp); n_fail++; end
    trigger_a = 4'b1000;
    ch_done_a = 4'b1000;
    tick;
    trigger_a = 4'b0000;
    ch_done_a = 4'b0000;
    exp = {4'b1100, 4'b1000, 4'b1011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL trig_beats_done got %b want %b", obs_a, exp); n_fail++; end
    tick;
    tick;
  endtask

  task automatic test_enable;
    logic [12:0] exp;
    ch_en_a = 4'b0111;
    trigger_a = 4'b1000;
    tick;
    trigger_a = 4'b0000;
    exp = {4'b1100, 4'b0000, 4'b0011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL en_gate got %b want %b", obs_a, exp); n_fail++; end
    ch_en_a = 4'b1111;
    tick;
    exp = {4'b1100, 4'b1000, 4'b1011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL en_rise1 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    n_tests++; if (obs_a !== exp) begin $display("FAIL en_rise2 got %b want %b", obs_a, exp); n_fail++; end
    tick;
    exp = {4'b0100, 4'b0000, 4'b1011, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL en_rise_done got %b want %b", obs_a, exp); n_fail++; end
  endtask

  task automatic test_master_off;
    logic [12:0] exp_off, exp;
    exp_off = {4'hF, 4'h0, 4'h0, 1'b0};
    master_en_a = 1'b0;
    tick;
    n_tests++; if (obs_a !== exp_off) begin $display("FAIL off_from_on got %b want %b", obs_a, exp_off); n_fail++; end
    master_en_a = 1'b1;
    tick;
    exp = {4'hF, 4'hF, 4'h0, 1'b0};
    n_tests++; if (obs_a !== exp) begin $display("FAIL off_rseq_entry got %b want %b", obs_a, exp); n_fail++; end
    master_en_a = 1'b0;
    tick;
    n_tests++; if (obs_a !== exp_off) begin $display("FAIL off_mid_rseq got %b want %b", obs_a, exp_off); n_fail++; end
    master_en_a = 1'b1;
    tick;
    tick;
    tick;
    exp = {4'h0, 4'h0, 4'hF, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL repower got %b want %b", obs_a, exp); n_fail++; end
    trigger_a = 4'b0001;
    tick;
    trigger_a = 4'b0000;
    exp = {4'b0001, 4'b0001, 4'hF, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL pulse_start got %b want %b", obs_a, exp); n_fail++; end
    master_en_a = 1'b0;
    tick;
    n_tests++; if (obs_a !== exp_off) begin $display("FAIL off_mid_pulse got %b want %b", obs_a, exp_off); n_fail++; end
  endtask

  task automatic test_async_reset;
    logic [12:0] exp_off, exp;
    exp_off = {4'hF, 4'h0, 4'h0, 1'b0};
    master_en_a = 1'b1;
    tick;
    tick;
    tick;
    exp = {4'h0, 4'h0, 4'hF, 1'b1};
    n_tests++; if (obs_a !== exp) begin $display("FAIL ar_on got %b want %b", obs_a, exp); n_fail++; end
    #2;
    reset_a = 1'b1;
    #1;
    n_tests++; if (obs_a !== exp_off) begin $display("FAIL ar_async got %b want %b", obs_a, exp_off); n_fail++; end
    master_en_a = 1'b0;
    reset_a = 1'b0;
    tick;
    n_tests++; if (obs_a !== exp_off) begin $display("FAIL ar_after got %b want %b", obs_a, exp_off); n_fail++; end
  endtask

  task automatic test_six_ch;
    logic [18:0] exp;
    ch_en_b = 6'b010101;
    master_en_b = 1'b1;
    tick;
    exp = {6'h3F, 6'h3F, 6'h00, 1'b0};
    n_tests++; if (obs_b !== exp) begin $display("FAIL b_rseq got %b want %b", obs_b, exp); n_fail++; end
    tick;
    exp = {6'b101010, 6'b000000, 6'b010101, 1'b1};
    n_tests++; if (obs_b !== exp) begin $display("FAIL b_on got %b want %b", obs_b, exp); n_fail++; end
    tick;
    n_tests++; if (obs_b !== exp) begin $display("FAIL b_no_extra got %b want %b", obs_b, exp); n_fail++; end
    trigger_b = 6'b000001;
    tick;
    trigger_b = 6'b000000;
    exp = {6'b101011, 6'b000001, 6'b010101, 1'b1};
    n_tests++; if (obs_b !== exp) begin $display("FAIL b_trig got %b want %b", obs_b, exp); n_fail++; end
    tick;
    exp = {6'b101010, 6'b000000, 6'b010101, 1'b1};
    n_tests++; if (obs_b !== exp) begin $display("FAIL b_trig_done got %b want %b", obs_b, exp); n_fail++; end
  endtask

  initial begin
    reset_a = 1'b1;  master_en_a = 1'b0;
    ch_en_a = '0;    trigger_a = '0;  ch_done_a = '0;
    reset_b = 1'b1;  master_en_b = 1'b0;
    ch_en_b = '0;    trigger_b = '0;  ch_done_b = '0;
    test_reset;
    test_power_up;
    test_trigger;
    test_length;
    test_enable;
    test_master_off;
    test_async_reset;
    test_six_ch;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
